// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding a single UART transmit stream, with mid-packet stall timeout.
// Optional owner-index header byte before each packet when UART_ARB_ID_TAG_EN is defined.
module uart_tx_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int N_PORTS    = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_PORTS-1:0]              s_axis_tvalid,
    input  logic [N_PORTS-1:0]              s_axis_tlast,
    output logic [N_PORTS-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [N_PORTS-1:0]              grant,
    output logic                            busy,
    output logic                            timeout_error
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef UART_ARB_ID_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

    state_t                  state, state_n;
    logic [IDX_W-1:0]        owner, owner_n;
    logic [IDX_W-1:0]        last_owner, last_owner_n;
    logic [N_PORTS-1:0]      grant_q, grant_n;
    logic [CNT_W-1:0]        stall_cnt, stall_n;
    logic                    timeout_n;

    logic [DATA_WIDTH-1:0]   own_data;
    logic                    own_valid;
    logic                    own_last;
    logic [IDX_W-1:0]        pick;
    logic                    pick_found;
    logic [IDX_W-1:0]        cand;

    assign own_data  = s_axis_tdata[owner*DATA_WIDTH +: DATA_WIDTH];
    assign own_valid = s_axis_tvalid[owner];
    assign own_last  = s_axis_tlast[owner];
    assign grant     = grant_q;
    assign busy      = (state != IDLE);

`ifdef UART_ARB_ID_TAG_EN
    logic [DATA_WIDTH-1:0] hdr_byte;
    always_comb begin
        hdr_byte              = '0;
        hdr_byte[IDX_W-1:0]   = owner;
    end
`endif

    // Scan starts one past the previous owner so every requester is served in turn.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            cand = IDX_W'((int'(last_owner) + int'(k)) % N_PORTS);
            if (!pick_found && s_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_n       = state;
        owner_n       = owner;
        last_owner_n  = last_owner;
        grant_n       = grant_q;
        stall_n       = stall_cnt;
        timeout_n     = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_n = pick;
                    grant_n = N_PORTS'(1) << pick;
                    stall_n = '0;
`ifdef UART_ARB_ID_TAG_EN
                    state_n = HDR;
`else
                    state_n = DATA;
`endif
                end
            end
`ifdef UART_ARB_ID_TAG_EN
            HDR: begin
                m_axis_tdata  = hdr_byte;
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    stall_n = '0;
                    state_n = DATA;
                end
            end
`endif
            DATA: begin
                m_axis_tdata  = own_data;
                m_axis_tvalid = own_valid;
                s_axis_tready = grant_q & {N_PORTS{m_axis_tready}};
                if (own_valid && m_axis_tready) begin
                    stall_n = '0;
                    if (own_last) begin
                        last_owner_n = owner;
                        grant_n      = '0;
                        state_n      = IDLE;
                    end
                end else if (!own_valid) begin
                    // Only a silent owner counts as stalled; downstream backpressure never does.
                    if (stall_cnt >= CNT_LAST) begin
                        timeout_n    = 1'b1;
                        last_owner_n = owner;
                        grant_n      = '0;
                        stall_n      = '0;
                        state_n      = IDLE;
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_n = stall_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= '0;
            last_owner    <= IDX_W'(N_PORTS - 1);
            grant_q       <= '0;
            stall_cnt     <= '0;
            timeout_error <= 1'b0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            last_owner    <= last_owner_n;
            grant_q       <= grant_n;
            stall_cnt     <= stall_n;
            timeout_error <= timeout_n;
        end
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of every stream.
REQ-002 SHALL have parameter N_PORTS, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 1024, mid-packet stall limit in clk cycles (>=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_axis_tdata  input  N_PORTS*DATA_WIDTH  requester bytes; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have ports s_axis_tvalid / s_axis_tlast  input  N_PORTS each  per-requester valid / end-of-packet.
REQ-008 SHALL have port s_axis_tready  output  N_PORTS  per-requester ready.
REQ-009 SHALL have ports m_axis_tdata  output  DATA_WIDTH, m_axis_tvalid  output  1, m_axis_tready  input  1  stream to the UART transmitter.
REQ-010 SHALL have port grant  output  N_PORTS  one-hot current owner, zero when idle.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.
REQ-012 SHALL have port timeout_error  output  1  single-cycle pulse on forced release.

Function
REQ-013 SHALL implement states IDLE, HDR, DATA; HDR exists only with UART_ARB_ID_TAG_EN.
REQ-014 IDLE: when any s_axis_tvalid is high, SHALL select the first valid port scanning round-robin from (last_owner+1) mod N_PORTS, register grant, and enter HDR or DATA next cycle; no byte is forwarded in the decision cycle.
REQ-015 In IDLE, SHALL drive s_axis_tready=0, m_axis_tvalid=0, grant=0.
REQ-016 DATA: m_axis_tdata/m_axis_tvalid SHALL equal the owner's tdata/tvalid combinationally; owner's tready SHALL equal m_axis_tready; all other tready SHALL be 0.
REQ-017 DATA: on a transfer (owner tvalid & m_axis_tready) with tlast=1, SHALL update last_owner, clear grant, return to IDLE.
REQ-018 The stall counter SHALL reset to 0 on every owner transfer and on entering DATA, and increment each DATA cycle the owner's tvalid is low; m_axis_tready low with tvalid high SHALL NOT count.
REQ-019 When the stall counter reaches TIMEOUT-1 and owner tvalid is still low, SHALL pulse timeout_error one cycle, update last_owner, and return to IDLE; owner's remaining bytes are then treated as a new packet.
REQ-020 A tlast transfer and timeout in the same cycle SHALL NOT occur (transfer clears counter); transfer takes precedence.
REQ-021 Requests from non-owners SHALL be held (not dropped) and arbitrated on the next IDLE.
REQ-022 Single requester repeatedly valid SHALL be re-granted each packet with one idle cycle between packets.
REQ-023 Stall counter width SHALL be clog2(TIMEOUT)+1 bits and saturate, never wrap.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, grant=0, last_owner=N_PORTS-1 (so port 0 wins first), stall counter=0, timeout_error=0, busy=0, all tready=0, m_axis_tvalid=0.
REQ-025 Reset mid-packet SHALL abandon the packet with no further output; first post-reset arbitration starts at port 0.

Configuration
REQ-026 Macro UART_ARB_ID_TAG_EN: when defined, after grant the block SHALL enter HDR and present m_axis_tdata = owner index (zero-extended), m_axis_tvalid=1, all s_axis_tready=0, moving to DATA on m_axis_tready; timeout counter idle in HDR.
REQ-027 When UART_ARB_ID_TAG_EN is undefined, no header byte SHALL be emitted and the grant cycle SHALL go directly to DATA.

Verification
REQ-028 Reset release, port 2 sends 3-byte packet 0x11,0x22,0x33(tlast), m_axis_tready=1 -> output 0x11,0x22,0x33 starting cycle 2 after tvalid, grant=4'b0100 during, busy falls after tlast.
REQ-029 Ports 0,1,3 all valid with 1-byte packets continuously -> grant order 0,1,3,0,1,3; no port granted twice before others served.
REQ-030 Port 1 granted, sends 0xAA then drops tvalid for TIMEOUT=16 cycles -> timeout_error pulses once on the 16th stall cycle, grant=0, next arbitration starts at port 2.
REQ-031 Port 0 mid-packet, m_axis_tready held low 50 cycles with TIMEOUT=16 -> no timeout_error, byte held stable, delivered when tready rises.
REQ-032 rst_n asserted asynchronously between clk edges during port 3 packet -> grant, m_axis_tvalid, s_axis_tready go 0 immediately; after release port 0 request wins.
REQ-033 With UART_ARB_ID_TAG_EN, port 2 sends 0x55(tlast) -> output sequence 0x02 then 0x55; without macro, output 0x55 only.
